// File: rtl/time_param_timer.sv
// time_param_timer
//   Bank of NUM_PARAMS programmable time parameters feeding a single
//   countdown timer. Software writes a parameter, then starts the timer
//   on one of them. The countdown decrements on each time-base tick.
//   It pulses 'expired' for one cycle when it runs out naturally.
//
// Ports
//   clk                      rising-edge clock
//   reset_n                  synchronous, active-low reset
//   reprogram                parameter write enable
//   time_parameter_selector  parameter index to write
//   time_value               write data
//   interval                 parameter index for readback and timer start
//   start_timer              load countdown from param[interval] and run
//   cancel                   abort countdown (no expired pulse)
//   tick                     one-clk time-base strobe
//   value                    combinational readback of param[interval]
//   count                    remaining count (registered)
//   busy                     high while counting (registered)
//   expired                  one-cycle pulse on natural expiry (registered)
//   active_interval          index latched at the last start (registered)
module time_param_timer #(
  parameter int WIDTH      = 4,
  parameter int NUM_PARAMS = 4,
  parameter int SEL_W      = $clog2(NUM_PARAMS),
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = {4'hA, 4'hF, 4'h8, 4'h6}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reprogram,
  input  logic [SEL_W-1:0] time_parameter_selector,
  input  logic [WIDTH-1:0] time_value,
  input  logic [SEL_W-1:0] interval,
  input  logic             start_timer,
  input  logic             cancel,
  input  logic             tick,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [SEL_W-1:0] active_interval
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] param [NUM_PARAMS];
  logic             wr_sel_ok;
  logic             rd_sel_ok;
  logic [WIDTH-1:0] load_val;

  assign wr_sel_ok = 32'(time_parameter_selector) < 32'(NUM_PARAMS);
  assign rd_sel_ok = 32'(interval) < 32'(NUM_PARAMS);

  always_comb begin
    value = '0;
    if (rd_sel_ok) value = param[interval];
  end

  // A write to the parameter being started in the same cycle is forwarded,
  // so the countdown sees the new value rather than the stale register.
  always_comb begin
    load_val = value;
    if (reprogram && wr_sel_ok && (time_parameter_selector == interval))
      load_val = time_value;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PARAMS; i++)
        param[i] <= DEFAULTS[i*WIDTH +: WIDTH];
      state           <= IDLE;
      busy            <= 1'b0;
      count           <= '0;
      expired         <= 1'b0;
      active_interval <= '0;
    end else begin
      // Parameter writes are independent of the countdown; the running
      // count is a private copy, so rewriting its source has no effect.
      for (int i = 0; i < NUM_PARAMS; i++)
        if (reprogram && (time_parameter_selector == SEL_W'(i)))
          param[i] <= time_value;

      expired <= 1'b0;

      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
        count <= '0;
      end else if (start_timer) begin
        active_interval <= interval;
        count           <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          // A zero-length interval expires immediately.
          state   <= IDLE;
          busy    <= 1'b0;
          expired <= 1'b1;
        end
      end else if ((state == RUN) && tick) begin
        if (count <= WIDTH'(1)) begin
          state   <= IDLE;
          busy    <= 1'b0;
          count   <= '0;
          expired <= 1'b1;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_param_timer.sv
module tb_time_param_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       reset_n, reprogram, start_timer, cancel, tick;
  logic [1:0] sel, interval, active_interval;
  logic [3:0] time_value, value, count;
  logic       busy, expired;

  time_param_timer u_dut (
    .clk(clk), .reset_n(reset_n), .reprogram(reprogram),
    .time_parameter_selector(sel), .time_value(time_value),
    .interval(interval), .start_timer(start_timer), .cancel(cancel),
    .tick(tick), .value(value), .count(count), .busy(busy),
    .expired(expired), .active_interval(active_interval)
  );

  // Wide instance: WIDTH=8, NUM_PARAMS=6
  logic       w_reset_n, w_reprogram, w_start, w_cancel, w_tick;
  logic [2:0] w_sel, w_interval, w_active;
  logic [7:0] w_time_value, w_value, w_count;
  logic       w_busy, w_expired;

  time_param_timer #(
    .WIDTH(8), .NUM_PARAMS(6),
    .DEFAULTS({8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10})
  ) u_wide (
    .clk(clk), .reset_n(w_reset_n), .reprogram(w_reprogram),
    .time_parameter_selector(w_sel), .time_value(w_time_value),
    .interval(w_interval), .start_timer(w_start), .cancel(w_cancel),
    .tick(w_tick), .value(w_value), .count(w_count), .busy(w_busy),
    .expired(w_expired), .active_interval(w_active)
  );

  typedef struct {
    logic       rst_n, rp;
    logic [1:0] sel;
    logic [3:0] tv;
    logic [1:0] iv;
    logic       st, cn, tk;
    logic [3:0] e_val, e_cnt;
    logic       e_busy, e_exp;
    logic [1:0] e_act;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(logic rst_n, logic rp, logic [1:0] s, logic [3:0] tv,
                              logic [1:0] iv, logic st, logic cn, logic tk,
                              logic [3:0] ev, logic [3:0] ec, logic eb, logic ee,
                              logic [1:0] ea);
    vec_t v;
    v.rst_n = rst_n; v.rp = rp; v.sel = s; v.tv = tv; v.iv = iv;
    v.st = st; v.cn = cn; v.tk = tk;
    v.e_val = ev; v.e_cnt = ec; v.e_busy = eb; v.e_exp = ee; v.e_act = ea;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  initial begin
    reset_n = 1'b0; reprogram = 1'b0; sel = '0; time_value = '0;
    interval = '0; start_timer = 1'b0; cancel = 1'b0; tick = 1'b0;
    w_reset_n = 1'b0; w_reprogram = 1'b0; w_sel = '0; w_time_value = '0;
    w_interval = '0; w_start = 1'b0; w_cancel = 1'b0; w_tick = 1'b0;

    //  rst rp sel tv iv st cn tk | val cnt busy exp act
    // reset and default readback
    add(0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0,   8, 0, 0, 0, 0);
    add(1, 0, 0, 0, 2, 0, 0, 0,  15, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 0,  10, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 1,  10, 0, 0, 0, 0);  // tick in IDLE ignored
    // write 3 to param 1, run it with a tick every 5 clocks
    add(1, 1, 1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0,   3, 3, 1, 0, 1);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 3, 3, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 2, 1, 0, 1);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 3, 2, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 1, 1, 0, 1);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0,   3, 0, 0, 0, 1);
    // write-through start (tick same cycle ignored), rewrite during RUN
    add(1, 1, 0, 2, 0, 1, 0, 1,   2, 2, 1, 0, 0);
    add(1, 1, 0, 9, 0, 0, 0, 0,   9, 2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,   9, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1,   9, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   9, 0, 0, 0, 0);
    // zero-length interval expires at once
    add(1, 1, 3, 0, 3, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 3, 0, 0, 0,   0, 0, 0, 0, 3);
    // cancel beats start
    add(1, 0, 0, 0, 2, 1, 0, 0,  15, 15, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 14, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 13, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 12, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 11, 1, 0, 2);
    add(1, 0, 0, 0, 2, 1, 1, 0,  15, 0, 0, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 0, 0, 0, 2);
    // restart while running: no pulse for the aborted run
    add(1, 0, 0, 0, 2, 1, 0, 0,  15, 15, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 14, 1, 0, 2);
    add(1, 0, 0, 0, 1, 1, 0, 1,   3, 3, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 2, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1,   3, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0,   3, 0, 0, 0, 1);
    // reset mid-countdown: no pulse, parameters back to defaults
    add(1, 0, 0, 0, 2, 1, 0, 0,  15, 15, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 14, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 13, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 12, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 11, 1, 0, 2);
    add(1, 0, 0, 0, 2, 0, 0, 1,  15, 10, 1, 0, 2);
    add(0, 1, 1, 5, 1, 1, 0, 1,   8, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 0,  10, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n; reprogram = tbl[i].rp; sel = tbl[i].sel;
      time_value = tbl[i].tv; interval = tbl[i].iv; start_timer = tbl[i].st;
      cancel = tbl[i].cn; tick = tbl[i].tk;
      @(posedge clk); #1;
      n_vec++;
      if (value !== tbl[i].e_val || count !== tbl[i].e_cnt || busy !== tbl[i].e_busy ||
          expired !== tbl[i].e_exp || active_interval !== tbl[i].e_act) begin
        n_fail++;
        $display("FAIL vec%0d: got val=%0d cnt=%0d busy=%0b exp=%0b act=%0d, expected val=%0d cnt=%0d busy=%0b exp=%0b act=%0d",
                 i, value, count, busy, expired, active_interval,
                 tbl[i].e_val, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_exp, tbl[i].e_act);
      end
    end
    reset_n = 1'b1; reprogram = 1'b0; start_timer = 1'b0; cancel = 1'b0; tick = 1'b0;

    // Wide instance: defaults, out-of-range handling, long run
    @(posedge clk); #1;
    w_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_interval = 3'(i);
      #1 chk($sformatf("wide_default%0d", i), int'(w_value), (i < 6) ? 10 * (i + 1) : 0);
    end
    w_reprogram = 1'b1; w_sel = 3'd7; w_time_value = 8'd99;
    @(posedge clk); #1;
    w_reprogram = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_interval = 3'(i);
      #1 chk($sformatf("wide_oor_write%0d", i), int'(w_value), (i < 6) ? 10 * (i + 1) : 0);
    end
    w_reprogram = 1'b1; w_sel = 3'd4; w_time_value = 8'd200;
    @(posedge clk); #1;
    w_reprogram = 1'b0; w_interval = 3'd4; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    chk("wide_load", int'(w_count), 200);
    chk("wide_busy_start", int'(w_busy), 1);
    chk("wide_active", int'(w_active), 4);
    w_tick = 1'b1;
    for (int k = 0; k < 199; k++) begin
      @(posedge clk); #1;
      if (w_expired !== 1'b0 || w_busy !== 1'b1) begin
        chk($sformatf("wide_early_tick%0d", k), int'({w_busy, w_expired}), 2);
      end
    end
    chk("wide_cnt_199", int'(w_count), 1);
    @(posedge clk); #1;
    w_tick = 1'b0;
    chk("wide_cnt_200", int'(w_count), 0);
    chk("wide_exp_200", int'(w_expired), 1);
    chk("wide_busy_200", int'(w_busy), 0);
    @(posedge clk); #1;
    chk("wide_exp_after", int'(w_expired), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/time_param_timer.md
TIME_PARAM_TIMER -- requirements
Module: time_param_timer

Interface
REQ-001 Parameter: WIDTH, 4, bit width of every time parameter and of the countdown.
REQ-002 Parameter: NUM_PARAMS, 4, number of programmable time parameters; must be 2 or more.
REQ-003 Parameter: SEL_W, $clog2(NUM_PARAMS), width of the selector ports.
REQ-004 Parameter: DEFAULTS, {4'hA,4'hF,4'h8,4'h6}, packed NUM_PARAMS*WIDTH reset values; index 0 sits in the LSBs (arm delay 6, driver door 8, passenger door 15, siren 10).
REQ-005 clk  in  1  Single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  Reset, synchronous, active-low.
REQ-007 reprogram  in  1  Parameter write enable, sampled each rising edge.
REQ-008 time_parameter_selector  in  SEL_W  Index of the parameter to write.
REQ-009 time_value  in  WIDTH  Write data.
REQ-010 interval  in  SEL_W  Index for the value readback and for timer start.
REQ-011 start_timer  in  1  Load the countdown from param[interval] and start it.
REQ-012 cancel  in  1  Abort the running countdown.
REQ-013 tick  in  1  Time-base enable strobe (1 Hz), one clk wide.
REQ-014 value  out  WIDTH  Combinational readback of param[interval].
REQ-015 count  out  WIDTH  Registered remaining count.
REQ-016 busy  out  1  Registered; high while the FSM is in RUN.
REQ-017 expired  out  1  Registered single-cycle pulse on natural expiry.
REQ-018 active_interval  out  SEL_W  Registered index latched at the last start.

Function
REQ-019 The block shall hold NUM_PARAMS registers of WIDTH bits, named param[i].
REQ-020 When reprogram=1 and time_parameter_selector<NUM_PARAMS, param[selector] shall take time_value at the edge; out-of-range selectors shall be ignored.
REQ-021 value shall equal param[interval], and 0 for out-of-range interval; a write becomes visible on value in the cycle after the write edge.
REQ-022 The FSM shall have two states: IDLE (busy=0) and RUN (busy=1).
REQ-023 Command priority each edge, highest first: reset, cancel, start_timer, tick; parameter writes proceed independently of the FSM.
REQ-024 On start_timer (in either state, cancel=0), the loaded value L shall be param[interval], or time_value when reprogram=1 and selector==interval in the same cycle (write-through); active_interval<=interval.
REQ-025 Start with L!=0: count<=L, state<=RUN; a tick in the same cycle shall be ignored.
REQ-026 Start with L==0: count<=0, state<=IDLE, expired<=1 at that edge.
REQ-027 Start while in RUN shall restart the countdown from the new L; no expired pulse for the aborted run.
REQ-028 In RUN with tick=1 and count>1: count<=count-1.
REQ-029 In RUN with tick=1 and count==1: count<=0, state<=IDLE, expired<=1; expired, count==0 and busy==0 shall appear together in the following cycle.
REQ-030 cancel=1 in any state: count<=0, state<=IDLE, expired<=0; active_interval shall be held.
REQ-031 tick in IDLE shall have no effect; count shall never wrap below 0.
REQ-032 expired shall be 0 on every edge not covered by REQ-026 or REQ-029.
REQ-033 Reprogramming param[active_interval] during RUN shall not alter the running count.

Reset
REQ-034 At a rising edge with reset_n=0: param[i]<=DEFAULTS[i], count<=0, state<=IDLE, busy<=0, expired<=0, active_interval<=0; all other inputs ignored.
REQ-035 Reset asserted mid-countdown shall abort the countdown without an expired pulse; parameter reprogramming is lost.

Verification
REQ-036 Release reset, sweep interval 0..3 -> value reads 6, 8, 15, 10.
REQ-037 Write sel=1, value 3, then start interval=1 with tick every 5 clk -> count 3,2,1,0; expired is high exactly one cycle, coincident with busy falling, 3 ticks after start.
REQ-038 Start interval=0 and on the same cycle reprogram sel=0 to 2 -> count loads 2; then write 9 to sel=0 during RUN -> count is unaffected and expiry comes after 2 ticks.
REQ-039 Write 0 to sel=3, start interval=3 -> busy stays 0 and expired pulses on the next cycle; then start interval=2 and assert cancel together with start after 4 ticks -> count=0, busy=0, no expired.
REQ-040 Start interval=2 (15), assert reset_n=0 after 5 ticks -> next cycle count=0, busy=0, expired=0, value for interval 1 back to 8.
REQ-041 Instantiate WIDTH=8, NUM_PARAMS=6 with custom DEFAULTS -> defaults read back; out-of-range write sel=7 is ignored; a run from 200 expires after exactly 200 ticks.
